tx_launch_scheduler: RTL and testbench

- Gates frame release from the TX frame slot memory to the sender, one frame at a time, in the gmii_tx_clk domain.
- Walks the slot ring from its own head pointer and reads each 8-word ethpipe header (magic, frame_len, 64-bit timestamp, hash) through a second slot read port.
- Releases a frame once global_counter has reached its timestamp, by advancing sched_wr_ptr, which drives the sender's mem_wr_ptr input.
- Halts on a malformed header.

---
 rtl/tx_launch_scheduler.sv | 117 +++++++++++
 tb/tb_tx_launch_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_launch_scheduler.sv
// Releases TX frames to the sender one at a time: walks the slot ring, reads each
// 8-word header through a second read port, and advances sched_wr_ptr once its timestamp is due.
module tx_launch_scheduler #(
   parameter logic [15:0] MAGIC         = 16'h5555,
   parameter logic [15:0] MAX_FRAME_LEN = 16'd1518,
   parameter logic [13:0] HDR_WORDS     = 14'd8
) (
   input  logic        gmii_tx_clk,
   input  logic        sys_rst_n,
   input  logic        sched_en,
   input  logic [63:0] global_counter,
   input  logic [13:0] mem_wr_ptr,
   output logic [13:0] slot_rd_addr,
   input  logic [15:0] slot_rd_q,
   output logic [13:0] sched_wr_ptr,
   input  logic [13:0] sender_rd_ptr,
   output logic        sched_busy,
   output logic        sender_idle,
   output logic        hdr_err,
   output logic [31:0] tx_released,
   output logic [31:0] wait_cycles
);

   typedef enum logic [2:0] {IDLE, HDR, CHECK, WAIT_TS, RELEASE, ERR} state_t;

   typedef struct packed {
      logic [15:0] magic;
      logic [15:0] frame_len;
      logic [63:0] ts;
   } hdr_t;

   state_t      state, state_nxt;
   hdr_t        hdr;
   logic [13:0] head;
   logic [3:0]  idx;
   logic [13:0] frame_end;
   logic        hdr_bad;
   logic        ts_reached;

   assign hdr_bad    = (hdr.magic != MAGIC) || (hdr.frame_len == 16'd0) ||
                       (hdr.frame_len > MAX_FRAME_LEN);
   assign ts_reached = (global_counter >= hdr.ts);
   assign frame_end  = head + hdr.frame_len[13:0] + HDR_WORDS;
   assign sched_busy = (state != IDLE);

   always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sched_en && (head != mem_wr_ptr)) state_nxt = HDR;
         HDR:     if (idx == 4'd8) state_nxt = CHECK;
         CHECK: begin
            if (hdr_bad)                state_nxt = ERR;
            else if (hdr.ts == 64'd0)   state_nxt = RELEASE;
            else                        state_nxt = WAIT_TS;
         end
         WAIT_TS: if (ts_reached) state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         ERR:     state_nxt = ERR;
         default: state_nxt = IDLE;
      endcase
   end

   // Read data lags the address register by one RAM cycle, so word (idx-1)
   // arrives while the address for word idx+1 is being issued.
   always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         head         <= '0;
         idx          <= '0;
         hdr          <= '0;
         slot_rd_addr <= '0;
         sched_wr_ptr <= '0;
         hdr_err      <= 1'b0;
         tx_released  <= '0;
         wait_cycles  <= '0;
      end else begin
         case (state)
            IDLE: begin
               slot_rd_addr <= head;
               idx          <= '0;
            end
            HDR: begin
               slot_rd_addr <= head + {10'd0, idx} + 14'd1;
               idx          <= idx + 4'd1;
               // hash words (6,7) are consumed by the sender, not by scheduling
               case (idx)
                  4'd1:    hdr.magic     <= slot_rd_q;
                  4'd2:    hdr.frame_len <= slot_rd_q;
                  4'd3:    hdr.ts[63:48] <= slot_rd_q;
                  4'd4:    hdr.ts[47:32] <= slot_rd_q;
                  4'd5:    hdr.ts[31:16] <= slot_rd_q;
                  4'd6:    hdr.ts[15:0]  <= slot_rd_q;
                  default: ;
               endcase
            end
            CHECK:   if (hdr_bad) hdr_err <= 1'b1;
            WAIT_TS: wait_cycles <= wait_cycles + 32'd1;
            RELEASE: begin
               sched_wr_ptr <= frame_end;
               head         <= frame_end;
               tx_released  <= tx_released + 32'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) sender_idle <= 1'b1;
      else            sender_idle <= (sender_rd_ptr == sched_wr_ptr);
   end

endmodule

// File: tb/tb_tx_launch_scheduler.sv
// Scoreboard bench: frames are written into a slot RAM model, a timing model predicts
// each release (pointer, cycle, count) and a monitor checks every sched_wr_ptr change.
module tb_tx_launch_scheduler;

   localparam logic [15:0] MAGIC = 16'h5555;

   logic        gmii_tx_clk = 1'b0;
   logic        sys_rst_n   = 1'b0;
   logic        sched_en    = 1'b0;
   logic [63:0] global_counter = 64'd0;
   logic [13:0] mem_wr_ptr  = 14'd0;
   logic [13:0] sender_rd_ptr = 14'h123;
   logic [15:0] slot_rd_q;
   logic [13:0] slot_rd_addr, sched_wr_ptr;
   logic        sched_busy, sender_idle, hdr_err;
   logic [31:0] tx_released, wait_cycles;

   tx_launch_scheduler dut (
      .gmii_tx_clk    (gmii_tx_clk),
      .sys_rst_n      (sys_rst_n),
      .sched_en       (sched_en),
      .global_counter (global_counter),
      .mem_wr_ptr     (mem_wr_ptr),
      .slot_rd_addr   (slot_rd_addr),
      .slot_rd_q      (slot_rd_q),
      .sched_wr_ptr   (sched_wr_ptr),
      .sender_rd_ptr  (sender_rd_ptr),
      .sched_busy     (sched_busy),
      .sender_idle    (sender_idle),
      .hdr_err        (hdr_err),
      .tx_released    (tx_released),
      .wait_cycles    (wait_cycles)
   );

   always #5 gmii_tx_clk = ~gmii_tx_clk;

   // Slot RAM with a one-cycle synchronous read.
   logic [15:0] mem [0:16383];
   always @(posedge gmii_tx_clk) slot_rd_q <= mem[slot_rd_addr];

   // Free-running time; the value seen at a rising edge is (value at next negedge) - 1.
   initial forever begin
      @(posedge gmii_tx_clk);
      #1 global_counter = global_counter + 64'd1;
   end

   typedef struct {
      logic [13:0]     end_ptr;
      longint unsigned edge_gc;
      int unsigned     cnt;
   } exp_t;

   exp_t            sb[$];
   logic [15:0]     stg_magic[$];
   logic [15:0]     stg_len[$];
   logic [63:0]     stg_ts[$];
   int              checks = 0;
   int              errors = 0;
   int unsigned     mcount = 0;
   longint unsigned mwait  = 0;
   bit              merr   = 1'b0;
   logic [13:0]     mhead  = 14'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic add_frame(input logic [15:0] magic, input logic [15:0] len, input logic [63:0] ts);
      stg_magic.push_back(magic);
      stg_len.push_back(len);
      stg_ts.push_back(ts);
   endtask

   // Writes staged frames at mem_wr_ptr and predicts releases. g_start is the
   // counter value at the first rising edge where the scheduler may leave IDLE.
   // Per frame: header read + check take 11 edges; a waiting frame is released on
   // the edge after the first edge (at or after its first wait edge) where time >= ts.
   task automatic stage(input longint unsigned g_start);
      logic [13:0]     a;
      longint unsigned g, gw, upd;
      exp_t            e;
      a = mem_wr_ptr;
      g = g_start;
      for (int i = 0; i < stg_len.size(); i++) begin
         mem[a]          = stg_magic[i];
         mem[a + 14'd1]  = stg_len[i];
         mem[a + 14'd2]  = stg_ts[i][63:48];
         mem[a + 14'd3]  = stg_ts[i][47:32];
         mem[a + 14'd4]  = stg_ts[i][31:16];
         mem[a + 14'd5]  = stg_ts[i][15:0];
         mem[a + 14'd6]  = 16'($urandom);
         mem[a + 14'd7]  = 16'($urandom);
         if (!merr) begin
            if (stg_magic[i] != MAGIC || stg_len[i] == 16'd0 || stg_len[i] > 16'd1518) begin
               merr = 1'b1;
            end else begin
               if (stg_ts[i] == 64'd0) begin
                  upd = g + 11;
               end else begin
                  gw    = (stg_ts[i] > g + 11) ? stg_ts[i] : g + 11;
                  mwait = mwait + (gw - (g + 11) + 1);
                  upd   = gw + 1;
               end
               mcount++;
               e.end_ptr = a + stg_len[i][13:0] + 14'd8;
               e.edge_gc = upd;
               e.cnt     = mcount;
               sb.push_back(e);
               mhead = e.end_ptr;
               g     = upd + 1;
            end
         end
         a = a + stg_len[i][13:0] + 14'd8;
      end
      mem_wr_ptr = a;
      stg_magic.delete();
      stg_len.delete();
      stg_ts.delete();
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge gmii_tx_clk);
         n++;
      end
      chk({name, "_drain_pending"}, sb.size(), 0);
      @(negedge gmii_tx_clk);
      chk({name, "_tx_released"}, tx_released, mcount);
      chk({name, "_wait_cycles"}, wait_cycles, mwait);
      chk({name, "_busy"}, sched_busy, 1'b0);
      chk({name, "_hdr_err"}, hdr_err, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge gmii_tx_clk);
      sys_rst_n  = 1'b0;
      sb.delete();
      mcount     = 0;
      mwait      = 0;
      merr       = 1'b0;
      mhead      = 14'd0;
      mem_wr_ptr = 14'd0;
      repeat (2) @(negedge gmii_tx_clk);
      sys_rst_n  = 1'b1;
   endtask

   task automatic check_frozen(input string name);
      repeat (60) @(negedge gmii_tx_clk);
      chk({name, "_hdr_err"}, hdr_err, 1'b1);
      chk({name, "_busy"}, sched_busy, 1'b1);
      chk({name, "_ptr_frozen"}, sched_wr_ptr, mhead);
      chk({name, "_tx_released"}, tx_released, mcount);
   endtask

   // Monitor: every pointer change must match the oldest predicted release.
   initial begin
      logic [13:0] prev;
      exp_t        e;
      prev = 14'd0;
      forever begin
         @(negedge gmii_tx_clk);
         if (!sys_rst_n) begin
            prev = 14'd0;
         end else if (sched_wr_ptr !== prev) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_release ptr=%0h prev=%0h", sched_wr_ptr, prev);
            end else begin
               e = sb.pop_front();
               chk("rel_ptr", sched_wr_ptr, e.end_ptr);
               chk("rel_cycle", global_counter - 64'd1, e.edge_gc);
               chk("rel_count", tx_released, e.cnt);
            end
            prev = sched_wr_ptr;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      int r;
      logic [63:0] ts;

      // Reset values
      repeat (3) @(negedge gmii_tx_clk);
      chk("rst_slot_rd_addr", slot_rd_addr, 0);
      chk("rst_sched_wr_ptr", sched_wr_ptr, 0);
      chk("rst_busy", sched_busy, 0);
      chk("rst_sender_idle", sender_idle, 1);
      chk("rst_hdr_err", hdr_err, 0);
      chk("rst_tx_released", tx_released, 0);
      chk("rst_wait_cycles", wait_cycles, 0);
      sys_rst_n = 1'b1;
      repeat (5) @(negedge gmii_tx_clk);
      chk("idle_empty_busy", sched_busy, 0);

      // Single frame, ts = 0: 0 -> 68, 11 edges after leaving IDLE
      sched_en = 1'b1;
      add_frame(MAGIC, 16'd60, 64'd0);
      stage(global_counter);
      drain("single", 200);
      chk("single_ptr_68", sched_wr_ptr, 14'd68);

      // Future timestamp, then one already in the past
      add_frame(MAGIC, 16'd100, global_counter + 64'd100);
      stage(global_counter);
      drain("future_ts", 400);
      add_frame(MAGIC, 16'd80, 64'd5);
      stage(global_counter);
      drain("past_ts", 200);

      // Back-to-back, including maximum length
      add_frame(MAGIC, 16'd60, 64'd0);
      add_frame(MAGIC, 16'd64, 64'd0);
      add_frame(MAGIC, 16'd1518, 64'd0);
      stage(global_counter);
      drain("b2b", 300);
      sender_rd_ptr = mhead;
      repeat (2) @(negedge gmii_tx_clk);
      chk("sender_idle_match", sender_idle, 1);
      sender_rd_ptr = mhead + 14'd1;
      repeat (2) @(negedge gmii_tx_clk);
      chk("sender_idle_behind", sender_idle, 0);

      // Randomized batches
      for (int b = 0; b < 6; b++) begin
         r = $urandom_range(1, 4);
         for (int i = 0; i < r; i++) begin
            case ($urandom_range(0, 3))
               0:       ts = 64'd0;
               1:       ts = global_counter + 64'($urandom_range(0, 200));
               2:       ts = 64'($urandom_range(1, 32'(global_counter)));
               default: ts = global_counter + 64'($urandom_range(0, 60));
            endcase
            add_frame(MAGIC, 16'($urandom_range(1, 1518)), ts);
         end
         stage(global_counter);
         drain("random", 3000);
      end

      // sched_en dropped mid-frame: the frame still releases
      add_frame(MAGIC, 16'd200, 64'd0);
      stage(global_counter);
      repeat (3) @(negedge gmii_tx_clk);
      sched_en = 1'b0;
      drain("en_mid_frame", 200);

      // sched_en low gates the IDLE exit
      add_frame(MAGIC, 16'd90, 64'd0);
      stage(global_counter + 64'd20);
      repeat (20) @(negedge gmii_tx_clk);
      chk("gated_busy", sched_busy, 0);
      sched_en = 1'b1;
      drain("gated", 200);

      // Reset while waiting on a timestamp
      add_frame(MAGIC, 16'd70, global_counter + 64'd5000);
      stage(global_counter);
      repeat (30) @(negedge gmii_tx_clk);
      @(posedge gmii_tx_clk);
      #3 sys_rst_n = 1'b0;
      #1;
      chk("arst_sched_wr_ptr", sched_wr_ptr, 0);
      chk("arst_slot_rd_addr", slot_rd_addr, 0);
      chk("arst_busy", sched_busy, 0);
      chk("arst_sender_idle", sender_idle, 1);
      chk("arst_tx_released", tx_released, 0);
      chk("arst_wait_cycles", wait_cycles, 0);
      sb.delete();
      mcount = 0;
      mwait  = 0;
      merr   = 1'b0;
      mhead  = 14'd0;
      @(negedge gmii_tx_clk);
      mem_wr_ptr = 14'd0;
      add_frame(MAGIC, 16'd100, 64'd0);
      stage(global_counter);
      sys_rst_n = 1'b1;
      drain("after_reset", 200);
      chk("after_reset_ptr", sched_wr_ptr, 14'd108);

      // Ring wrap: fill up to 0x3FF0, then a 60-word frame wraps through 0
      do_reset();
      for (int i = 0; i < 10; i++) add_frame(MAGIC, 16'd1518, 64'd0);
      add_frame(MAGIC, 16'd1100, 64'd0);
      add_frame(MAGIC, 16'd60, 64'd0);
      stage(global_counter);
      drain("wrap", 400);
      chk("wrap_ptr", sched_wr_ptr, 14'h0034);

      // Malformed headers halt scheduling; the following valid frame never goes
      add_frame(16'h1234, 16'd60, 64'd0);
      add_frame(MAGIC, 16'd60, 64'd0);
      stage(global_counter);
      check_frozen("bad_magic");

      do_reset();
      add_frame(MAGIC, 16'd0, 64'd0);
      add_frame(MAGIC, 16'd60, 64'd0);
      stage(global_counter);
      check_frozen("bad_len0");

      do_reset();
      add_frame(MAGIC, 16'd2000, 64'd0);
      add_frame(MAGIC, 16'd60, 64'd0);
      stage(global_counter);
      check_frozen("bad_len2000");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
